// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants and the coordinate type used by the
// sync generator and the colour stage.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster position and timing bundle from the sync generator (master) to the
// colour stage and monitor pins (slave).
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    coord_t CounterX;
    coord_t CounterY;
    logic   hsync;
    logic   vsync;
    logic   in_display;
    logic   line_start;
    logic   frame_start;

    modport master (
        output CounterX, CounterY, hsync, vsync, in_display, line_start, frame_start
    );

    modport slave (
        input CounterX, CounterY, hsync, vsync, in_display, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Generic wrapping raster counter with registered sync-window and active-region
// decodes, computed from the next count so they stay aligned with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int ACTIVE     = DEF_H_ACTIVE,
    parameter int SYNC_START = DEF_H_SYNC_START,
    parameter int SYNC_END   = DEF_H_SYNC_END,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output coord_t count,
    output logic   wrap,
    output logic   sync,
    output logic   active
);

    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t ACT_END = coord_t'(ACTIVE);
    localparam coord_t SYNC_LO = coord_t'(SYNC_START);
    localparam coord_t SYNC_HI = coord_t'(SYNC_END);

    coord_t count_nxt;

    // NOTE: combinational logic uses blocking '=' with every output assigned on
    // all paths (no latch); the registers below use non-blocking '<=' only.
    always_comb begin
        count_nxt = count + 1'b1;
        if (count == LAST) count_nxt = '0;
    end

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            sync   <= ~SYNC_POL;
            active <= 1'b1;
        end else if (en) begin
            count  <= count_nxt;
            sync   <= (count_nxt >= SYNC_LO && count_nxt <= SYNC_HI) ? SYNC_POL : ~SYNC_POL;
            active <= (count_nxt < ACT_END);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster/sync generator. Define VGA_SYNC_DELAY_EN to delay hsync/vsync by
// one pixel so they line up with the colour stage's registered RGB.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_timing
            $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
        end
    endgenerate

    coord_t h_count, v_count;
    logic   h_wrap, v_wrap, h_sync, v_sync, h_act, v_act, v_en;
    logic   line_start_q, frame_start_q;

    // The vertical axis steps only on the horizontal wrap.
    assign v_en = pix_en & h_wrap;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC - 1),
        .SYNC_POL(H_SYNC_POL)
    ) u_h (
        .clk(clk), .reset(reset), .en(pix_en),
        .count(h_count), .wrap(h_wrap), .sync(h_sync), .active(h_act)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC - 1),
        .SYNC_POL(V_SYNC_POL)
    ) u_v (
        .clk(clk), .reset(reset), .en(v_en),
        .count(v_count), .wrap(v_wrap), .sync(v_sync), .active(v_act)
    );

    // Wraps are already gated by pix_en, so the strobes drop whenever it is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= h_wrap;
            frame_start_q <= h_wrap & v_wrap;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic h_sync_q, v_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync_q <= ~H_SYNC_POL;
            v_sync_q <= ~V_SYNC_POL;
        end else if (pix_en) begin
            h_sync_q <= h_sync;
            v_sync_q <= v_sync;
        end
    end

    assign vga.hsync = h_sync_q;
    assign vga.vsync = v_sync_q;
`else
    assign vga.hsync = h_sync;
    assign vga.vsync = v_sync;
`endif

    assign vga.CounterX    = h_count;
    assign vga.CounterY    = v_count;
    assign vga.in_display  = h_act & v_act;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: a full-size and a reduced-timing generator run side by
// side against a behavioural raster model through expected-value queues.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   hs;
        logic   vs;
        logic   de;
        logic   ls;
        logic   fs;
    } obs_t;

    typedef struct packed {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
        bit hpol; bit vpol;
    } tim_t;

    localparam tim_t BIG = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    localparam tim_t SML = '{20, 4, 6, 4, 12, 3, 2, 4, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen_if big_if ();
    vga_sync_gen_if sml_if ();

    vga_sync_gen dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vga(big_if)
    );

    vga_sync_gen #(
        .H_ACTIVE(SML.ha), .H_FP(SML.hfp), .H_SYNC(SML.hsw), .H_BP(SML.hbp),
        .V_ACTIVE(SML.va), .V_FP(SML.vfp), .V_SYNC(SML.vsw), .V_BP(SML.vbp),
        .H_SYNC_POL(SML.hpol), .V_SYNC_POL(SML.vpol)
    ) dut_sml (
        .clk(clk), .reset(reset), .pix_en(pix_en), .vga(sml_if)
    );

    obs_t q_big[$];
    obs_t q_sml[$];
    obs_t m_big, m_sml, e_b, e_s;
    int   total = 0;
    int   bad = 0;

    function automatic bit in_win(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic obs_t rst_obs(tim_t t);
        obs_t o;
        o.x = '0; o.y = '0;
        o.hs = !t.hpol; o.vs = !t.vpol;
        o.de = 1'b1; o.ls = 1'b0; o.fs = 1'b0;
        return o;
    endfunction

    // Behavioural raster: what the outputs should show after one clk edge.
    function automatic obs_t model_step(obs_t p, bit pe, tim_t t);
        obs_t n = p;
        int   ht = t.ha + t.hfp + t.hsw + t.hbp;
        int   vt = t.va + t.vfp + t.vsw + t.vbp;
        int   px = int'(p.x), py = int'(p.y), nx, ny, sx, sy;
        bit   wx, wy;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (pe) begin
            wx = (px == ht - 1);
            wy = (py == vt - 1);
            nx = wx ? 0 : px + 1;
            ny = wx ? (wy ? 0 : py + 1) : py;
            n.x  = coord_t'(nx);
            n.y  = coord_t'(ny);
            n.ls = wx;
            n.fs = wx && wy;
            n.de = (nx < t.ha) && (ny < t.va);
`ifdef VGA_SYNC_DELAY_EN
            sx = px; sy = py;
`else
            sx = nx; sy = ny;
`endif
            n.hs = in_win(sx, t.ha + t.hfp, t.ha + t.hfp + t.hsw - 1) ? t.hpol : !t.hpol;
            n.vs = in_win(sy, t.va + t.vfp, t.va + t.vfp + t.vsw - 1) ? t.vpol : !t.vpol;
        end
        return n;
    endfunction

    function automatic obs_t get_big();
        obs_t o;
        o.x = big_if.CounterX; o.y = big_if.CounterY;
        o.hs = big_if.hsync; o.vs = big_if.vsync; o.de = big_if.in_display;
        o.ls = big_if.line_start; o.fs = big_if.frame_start;
        return o;
    endfunction

    function automatic obs_t get_sml();
        obs_t o;
        o.x = sml_if.CounterX; o.y = sml_if.CounterY;
        o.hs = sml_if.hsync; o.vs = sml_if.vsync; o.de = sml_if.in_display;
        o.ls = sml_if.line_start; o.fs = sml_if.frame_start;
        return o;
    endfunction

    // Drive one clk with the given pix_en and queue what both DUTs should show.
    task automatic advance(input bit pe);
        pix_en = pe;
        m_big = model_step(m_big, pe, BIG);
        m_sml = model_step(m_sml, pe, SML);
        q_big.push_back(m_big);
        q_sml.push_back(m_sml);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pix_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 2;
        if (get_big() !== rst_obs(BIG)) begin
            bad++; $display("FAIL reset_big act=%p exp=%p", get_big(), rst_obs(BIG));
        end
        if (get_sml() !== rst_obs(SML)) begin
            bad++; $display("FAIL reset_sml act=%p exp=%p", get_sml(), rst_obs(SML));
        end
        m_big = rst_obs(BIG);
        m_sml = rst_obs(SML);
        reset = 1'b0;
    endtask

    task automatic test_first_advance();
        advance(1'b1);
        e_b = q_big.pop_front();
        e_s = q_sml.pop_front();
        total += 2;
        if (get_big() !== e_b) begin
            bad++; $display("FAIL first_adv_big act=%p exp=%p", get_big(), e_b);
        end
        if (get_sml() !== e_s) begin
            bad++; $display("FAIL first_adv_sml act=%p exp=%p", get_sml(), e_s);
        end
    endtask

    // Two full-size lines (hsync window, blanking, line wrap) and two small frames.
    task automatic test_lines();
        for (int i = 0; i < 1700; i++) begin
            advance(1'b1);
            e_b = q_big.pop_front();
            e_s = q_sml.pop_front();
            total += 2;
            if (get_big() !== e_b) begin
                bad++; $display("FAIL lines_big i=%0d act=%p exp=%p", i, get_big(), e_b);
            end
            if (get_sml() !== e_s) begin
                bad++; $display("FAIL lines_sml i=%0d act=%p exp=%p", i, get_sml(), e_s);
            end
        end
    endtask

    task automatic test_pix_en_toggle();
        for (int i = 0; i < 200; i++) begin
            advance(i % 2 == 0);
            e_b = q_big.pop_front();
            e_s = q_sml.pop_front();
            total += 2;
            if (get_big() !== e_b) begin
                bad++; $display("FAIL toggle_big i=%0d act=%p exp=%p", i, get_big(), e_b);
            end
            if (get_sml() !== e_s) begin
                bad++; $display("FAIL toggle_sml i=%0d act=%p exp=%p", i, get_sml(), e_s);
            end
        end
    endtask

    // Frame period of the reduced-timing instance, measured between frame_start strobes.
    task automatic test_back_to_back();
        int first = -1;
        int period = -1;
        int frame = (SML.ha + SML.hfp + SML.hsw + SML.hbp) * (SML.va + SML.vfp + SML.vsw + SML.vbp);
        for (int i = 0; i < 2 * frame + 10 && period < 0; i++) begin
            advance(1'b1);
            e_b = q_big.pop_front();
            e_s = q_sml.pop_front();
            total += 2;
            if (get_big() !== e_b) begin
                bad++; $display("FAIL b2b_big i=%0d act=%p exp=%p", i, get_big(), e_b);
            end
            if (get_sml() !== e_s) begin
                bad++; $display("FAIL b2b_sml i=%0d act=%p exp=%p", i, get_sml(), e_s);
            end
            if (sml_if.frame_start === 1'b1) begin
                if (first < 0) first = i;
                else period = i - first;
            end
        end
        total++;
        if (period !== frame) begin
            bad++; $display("FAIL frame_period act=%0d exp=%0d", period, frame);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 900 && int'(m_big.x) != 400; i++) begin
            advance(1'b1);
            e_b = q_big.pop_front();
            e_s = q_sml.pop_front();
            total += 2;
            if (get_big() !== e_b) begin
                bad++; $display("FAIL mid_big i=%0d act=%p exp=%p", i, get_big(), e_b);
            end
            if (get_sml() !== e_s) begin
                bad++; $display("FAIL mid_sml i=%0d act=%p exp=%p", i, get_sml(), e_s);
            end
        end
        total++;
        if (big_if.CounterX !== 10'd400) begin
            bad++; $display("FAIL reach_400 act=%0d exp=400", big_if.CounterX);
        end
        reset = 1'b1;
        #2;
        total += 2;
        if (get_big() !== rst_obs(BIG)) begin
            bad++; $display("FAIL async_rst_big act=%p exp=%p", get_big(), rst_obs(BIG));
        end
        if (get_sml() !== rst_obs(SML)) begin
            bad++; $display("FAIL async_rst_sml act=%p exp=%p", get_sml(), rst_obs(SML));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_big = rst_obs(BIG);
        m_sml = rst_obs(SML);
        for (int i = 0; i < 3; i++) begin
            advance(1'b1);
            e_b = q_big.pop_front();
            e_s = q_sml.pop_front();
            total += 2;
            if (get_big() !== e_b) begin
                bad++; $display("FAIL restart_big i=%0d act=%p exp=%p", i, get_big(), e_b);
            end
            if (get_sml() !== e_s) begin
                bad++; $display("FAIL restart_sml i=%0d act=%p exp=%p", i, get_sml(), e_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_advance();
        test_lines();
        test_pix_en_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
